// File: rtl/addsub_seq_if.sv
// addsub_seq_if: operand/result handshake bundle for addsub_seq.
//   master: drives in_valid, a, b, sub, out_ready; sees in_ready, out_valid, s and flags.
//   slave : the arithmetic unit (mirror of master).
// WIDTH must match the WIDTH of the attached addsub_seq.
interface addsub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             overflow;
    logic             neg;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, overflow, neg, carry, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, overflow, neg, carry, zero
    );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
// Operands are consumed CHUNK bits per clock through a registered ripple
// carry; one operation in flight at a time (IDLE -> RUN x NCH -> DONE).
//
// Parameters:
//   WIDTH  operand/result width, multiple of CHUNK, >= 2
//   CHUNK  bits added per cycle (CHUNK == WIDTH gives a single RUN cycle)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    addsub_seq_if.slave:
//            in_valid/in_ready  operand handshake (in_ready only in IDLE)
//            a, b, sub          operands; sub=1 computes a-b
//            out_valid/out_ready result handshake (out_valid only in DONE)
//            s, overflow, neg, carry, zero  result and flags, held in DONE
// Configuration macro:
//   ADDSUB_SAT_EN  when defined, s saturates to the signed max/min on overflow;
//                  overflow and carry still report the raw result.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_seq_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // A operand, shifted down one chunk per RUN cycle
    logic [WIDTH-1:0] b_q, b_d;       // B or ~B, shifted the same way
    logic [WIDTH-1:0] r_q, r_d;       // partial result, filled from the top down
    logic             c_q, c_d;       // ripple carry between chunks
    logic [KW-1:0]    k_q, k_d;       // chunk index
    logic [WIDTH-1:0] s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    // Chunk datapath: always works on the low CHUNK bits of the shifted
    // operand registers, so no variable part-select mux is needed.
    logic [CHUNK:0]   csum;
    logic             cmsb;           // carry into the result MSB (valid on last chunk)
    logic             ovf_raw;
    logic             last;
    logic [WIDTH-1:0] raw;            // result register contents after this chunk
    logic [WIDTH-1:0] res;            // value presented on s (after optional saturation)

    always_comb begin
        csum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
        // Sum bit = a ^ b ^ cin, so the carry into the top bit falls out of it.
        cmsb    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];
        ovf_raw = cmsb ^ csum[CHUNK];
        last    = (k_q == KW'(NCH - 1));
        raw     = (r_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
`ifdef ADDSUB_SAT_EN
        // On the last chunk a_q[CHUNK-1] is still the original sign of A.
        if (ovf_raw) begin
            res = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res = raw;
        end
`else
        res = raw;
`endif
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        c_d         = c_q;
        k_d         = k_q;
        s_d         = s_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        zero_d      = zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is A + ~B + 1: the +1 rides in as the initial
                    // carry, so -B is never formed (safe for B = most-negative).
                    a_d        = bus.a;
                    b_d        = bus.sub ? ~bus.b : bus.b;
                    c_d        = bus.sub;
                    k_d        = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                r_d = raw;
                c_d = csum[CHUNK];
                a_d = a_q >> CHUNK;
                b_d = b_q >> CHUNK;
                if (last) begin
                    // Flags are latched together with s on DONE entry.
                    k_d         = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    s_d         = res;
                    ovf_d       = ovf_raw;
                    carry_d     = csum[CHUNK];
                    neg_d       = res[WIDTH-1];
                    zero_d      = (res == '0);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            c_q         <= 1'b0;
            k_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            c_q         <= c_d;
            k_q         <= k_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.overflow  = ovf_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed checks on a WIDTH=16/CHUNK=4 unit plus randomized
// traffic on four configurations (16/4, 16/1, 16/16, 32/8), all compared
// against a signed-arithmetic reference model.
module tb_addsub_seq;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed result, then wrap or saturate.
    // Returns {overflow, neg, carry, zero, s[63:0]}.
    function automatic logic [67:0] model(input int w, input longint unsigned a,
                                          input longint unsigned b, input bit sub);
        longint unsigned mask, s64;
        longint sa, sb, ex, mx, mn;
        bit ov, c;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        ex   = sub ? sa - sb : sa + sb;
        mx   = longint'((64'd1 << (w - 1)) - 64'd1);
        mn   = -longint'(64'd1 << (w - 1));
        ov   = (ex > mx) || (ex < mn);
        c    = sub ? (a >= b) : ((a + b) > mask);
        if (SAT && ov) s64 = longint'(sa < 0 ? mn : mx);
        else           s64 = longint'(ex);
        s64 = s64 & mask;
        return {ov, s64[w-1], c, (s64 == 64'd0), s64};
    endfunction

    function automatic longint unsigned pick(input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom % 8)
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return mask;
            3:       return 64'd1 << (w - 1);
            4:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {32'd0, $urandom} & mask;
        endcase
    endfunction

    // ---------------- directed unit ----------------
    logic rst_n;
    addsub_seq_if #(.WIDTH(16)) bus ();
    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ta, input logic [15:0] tbv, input logic ts);
        bit ok;
        ok = 1'b0;
        bus.a = ta; bus.b = tbv; bus.sub = ts; bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.in_ready;
            tick;
        end
        // Scramble operands after accept; the unit must ignore them.
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = 1'($urandom);
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_ov(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick;
            lat++;
        end
    endtask

    task automatic run_dir(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                           input logic ts, input logic [15:0] es, input logic [3:0] ef);
        int lat;
        bus.out_ready = 1'b1;
        issue(ta, tbv, ts);
        wait_ov(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_s"}, 64'(bus.s), 64'(es));
        chk({tag, "_flags(o,n,c,z)"}, 64'({bus.overflow, bus.neg, bus.carry, bus.zero}), 64'(ef));
        tick;
        chk({tag, "_taken(ov,ir)"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0;
        repeat (2) tick;
        chk("rst_state", 64'({bus.in_ready, bus.out_valid, bus.overflow, bus.neg, bus.carry, bus.zero}),
            64'(6'b100000));
        chk("rst_s", 64'(bus.s), 64'd0);
        rst_n = 1'b1;
        tick;

        run_dir("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000,
                {1'b1, !SAT, 1'b0, 1'b0});
        run_dir("sub_5_7",    16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b0100);
        run_dir("sub_7_5",    16'h0007, 16'h0005, 1'b1, 16'h0002, 4'b0010);
        run_dir("sub_8000_1", 16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF,
                {1'b1, SAT, 1'b1, 1'b0});
        run_dir("sub_0_8000", 16'h0000, 16'h8000, 1'b1, SAT ? 16'h7FFF : 16'h8000,
                {1'b1, !SAT, 1'b0, 1'b0});
        run_dir("add_zero",   16'h1234, 16'hEDCC, 1'b0, 16'h0000, 4'b0011);

        // Stall the consumer for 10 cycles while offering new operands.
        bus.out_ready = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0);
        wait_ov(lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.a = 16'h5555; bus.b = 16'h0F0F; bus.sub = 1'b1;
            tick;
            chk("hold_ov_ir", 64'({bus.out_valid, bus.in_ready}), 64'(2'b10));
            chk("hold_s", 64'(bus.s), 64'h3333);
            chk("hold_flags", 64'({bus.overflow, bus.neg, bus.carry, bus.zero}), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk("hold_release", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
        tick;
        chk("hold_no_ghost", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));

        // Reset during the second RUN cycle.
        bus.out_ready = 1'b1;
        issue(16'hAAAA, 16'h1111, 1'b0);
        tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 64'({bus.in_ready, bus.out_valid, bus.overflow, bus.neg, bus.carry, bus.zero}),
            64'(6'b100000));
        chk("midrst_s", 64'(bus.s), 64'd0);
        tick;
        rst_n = 1'b1;
        tick;
        run_dir("post_rst", 16'h0100, 16'h0200, 1'b0, 16'h0300, 4'b0000);

        // Let the randomized configurations finish.
        for (int i = 0; i < 40000 && !(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done); i++)
            @(posedge clk);
        chk("random_done", 64'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done, g_cfg[3].done}), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // ---------------- randomized configurations ----------------
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = (g == 3) ? 32 : 16;
        localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 8;
        localparam int N = W / C;

        logic rn;
        bit   done = 1'b0;
        addsub_seq_if #(.WIDTH(W)) rb ();
        addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rn), .bus(rb));

        initial begin
            logic [W-1:0] ta, tbv;
            logic         ts;
            logic [67:0]  e;
            bit           acc, seen, taken;
            int           lat;
            rn = 1'b0;
            rb.in_valid = 1'b0; rb.out_ready = 1'b0;
            rb.a = '0; rb.b = '0; rb.sub = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rn = 1'b1;
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                ta  = W'(pick(W));
                tbv = W'(pick(W));
                ts  = 1'($urandom);
                rb.a = ta; rb.b = tbv; rb.sub = ts; rb.in_valid = 1'b1;
                acc = 1'b0;
                for (int i = 0; i < 50 && !acc; i++) begin
                    acc = rb.in_ready;
                    rb.out_ready = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                rb.in_valid = 1'b0;
                rb.a = W'($urandom); rb.b = W'($urandom); rb.sub = 1'($urandom);
                if (!acc) chk($sformatf("cfg%0d_accept_timeout", g), 64'd0, 64'd1);
                e = model(W, 64'(ta), 64'(tbv), ts);
                lat = 0; seen = 1'b0; taken = 1'b0;
                for (int i = 0; i < 200 && !taken; i++) begin
                    if (rb.out_valid) begin
                        if (!seen) chk($sformatf("cfg%0d_lat", g), 64'(lat), 64'(N));
                        seen = 1'b1;
                        chk($sformatf("cfg%0d_s a=%0h b=%0h sub=%0d", g, ta, tbv, ts), 64'(rb.s), e[63:0]);
                        chk($sformatf("cfg%0d_flags a=%0h b=%0h sub=%0d", g, ta, tbv, ts),
                            64'({rb.overflow, rb.neg, rb.carry, rb.zero}), 64'(e[67:64]));
                        rb.out_ready = ($urandom % 4) != 0;
                        taken = rb.out_ready;
                    end else begin
                        rb.out_ready = 1'($urandom);
                    end
                    @(posedge clk);
                    #1;
                    lat++;
                end
                if (!taken) chk($sformatf("cfg%0d_result_timeout", g), 64'd0, 64'd1);
                chk($sformatf("cfg%0d_taken", g), 64'({rb.out_valid, rb.in_ready}), 64'(2'b01));
            end
            done = 1'b1;
        end
    end
endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle two's-complement adder-subtractor. Processes the operands CHUNK bits per clock through a registered ripple carry, so area scales with CHUNK and latency with WIDTH/CHUNK. It has valid/ready handshakes on both sides and reports overflow, negative, carry and zero flags. It is the general-purpose arithmetic unit for datapaths wider than 8 bits, and it replaces the fixed 8-bit combinational add/sub.

## Interface
- WIDTH, default 16: operand/result width. Must be a multiple of CHUNK and at least 2.
- CHUNK, default 4: bits processed per cycle. CHUNK = WIDTH gives single-pass operation.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  WIDTH  operand A, signed two's complement.
- b  in  WIDTH  operand B, signed two's complement.
- sub  in  1  1 computes A−B; 0 computes A+B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  result.
- overflow  out  1  signed overflow.
- neg  out  1  sign bit of the final s.
- carry  out  1  carry out of MSB; for sub, 1 means no borrow.
- zero  out  1  s == 0.

## Operation
- NCH = WIDTH/CHUNK. States are IDLE, RUN and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a into the A register.
  - latch b (sub=0) or ~b (sub=1) into the B register.
  - set carry register to sub.
  - clear chunk index k to 0 and go to RUN.
- RUN, each cycle:
  - compute chunk k as A[k] + B'[k] + c, write it into the result register, and update c.
  - on the last chunk (k=NCH−1), also record the carry into the MSB (cmsb), then go to DONE.
  - otherwise increment k.
- Subtraction is A + ~B + 1. Do not form −B separately; this gives correct flags for B = most-negative.
- DONE: out_valid=1. s and flags stay stable until out_ready, then go to IDLE.
- in_ready=0 in RUN and DONE. There is no overlap: one operation is in flight at a time.
- Flags, computed once at the end of RUN from raw results:
  - carry = final c.
  - overflow = cmsb XOR c.
  - neg = s[WIDTH−1] after the optional saturation.
  - zero = (s == 0) after the optional saturation.
- Operand inputs are ignored outside the accepting edge. Changing them mid-operation has no effect.
- out_ready while out_valid=0 is ignored.

## Timing
- Reset (async assert, sync-free release): state=IDLE, in_ready=1, out_valid=0, s=0, all flags=0, k=0, c=0.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result. The next operation after release is unaffected.
- With the accept edge at T, out_valid rises at edge T+NCH and stays high until the edge where out_ready=1.
- in_ready rises one cycle after the result is taken (DONE→IDLE).
- Minimum issue interval is NCH+2 cycles.
- If out_ready is already high when out_valid rises, the result is consumed on the next edge (edge T+NCH+1).
- CHUNK=WIDTH: NCH=1, latency 1 cycle.

## Configuration
- ADDSUB_SAT_EN defined: saturating mode.
  - On overflow, s becomes 0111…1 if A was non-negative, or 1000…0 if A was negative.
  - overflow stays 1; carry reports the raw carry.
  - The saturation mux is applied in the DONE-entry cycle and adds no latency.
- ADDSUB_SAT_EN undefined: s is the raw wrapped sum, and the saturation logic is absent.

## Test plan
WIDTH=16, CHUNK=4 unless noted.
- Add 0x7FFF + 0x0001 → s=0x8000, overflow=1, neg=1, carry=0, zero=0, out_valid exactly 4 cycles after accept. With ADDSUB_SAT_EN: s=0x7FFF, neg=0.
- Sub 0x0005 − 0x0007 → s=0xFFFE, neg=1, carry=0, overflow=0. Sub 0x0007 − 0x0005 → s=0x0002, carry=1.
- Sub 0x8000 − 0x0001 → s=0x7FFF, overflow=1. With ADDSUB_SAT_EN: s=0x8000. Sub 0x0000 − 0x8000 → overflow=1. Add 0x1234 + 0xEDCC → s=0x0000, zero=1, carry=1.
- Hold out_ready=0 for 10 cycles after out_valid:
  - s and flags stay stable, in_ready=0, and new in_valid is ignored.
  - after out_ready pulses, in_ready rises the next cycle.
- Assert rst_n=0 at RUN cycle 2, then release:
  - all outputs return to reset values immediately.
  - the next operation 0x0100 + 0x0200 → 0x0300.
- Random back-to-back ops with random in_valid/out_ready gaps checked against a reference model, for CHUNK ∈ {1, 4, 16} (CHUNK=16 shows latency 1) and WIDTH=32/CHUNK=8.
